// File: rtl/rtc_counter_core.sv
// rtc_counter_core: RTC time counter with CDC control sync, load handshake, match and wrap events
module rtc_counter_core #(
    parameter int CNT_W = 32
) (
    input  logic             i_rtc_ext_clk,
    input  logic             presetn,
    input  logic             tick_en,
    input  logic             rtc_en,
    input  logic             load_req_tgl,
    input  logic [CNT_W-1:0] load_val,
    output logic             load_ack_tgl,
    input  logic             match_en,
    input  logic [CNT_W-1:0] match_val,
    input  logic             sts_clr_tgl,
    output logic [CNT_W-1:0] cnt_val,
    output logic             match_pulse,
    output logic             match_sts,
    output logic             wrap_pulse
);
    logic [1:0]       en_sync_q, en_sync_d;
    logic [1:0]       men_sync_q, men_sync_d;
    logic [1:0]       ld_sync_q, ld_sync_d;
    logic [1:0]       clr_sync_q, clr_sync_d;
    logic             ld_del_q, ld_del_d;
    logic             clr_del_q, clr_del_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             mp_q, mp_d;
    logic             sts_q, sts_d;
    logic             wp_q, wp_d;
    logic             en_s, men_s, ld_s, clr_s;
    logic             load_evt, clr_evt, inc;
    logic [CNT_W-1:0] cnt_inc;

    assign en_s  = en_sync_q[1];
    assign men_s = men_sync_q[1];
    assign ld_s  = ld_sync_q[1];
    assign clr_s = clr_sync_q[1];

    // Two-flop synchronisers for the pclk-domain controls, plus a third flop on the toggles for edge detection
    always_comb begin
        en_sync_d  = {en_sync_q[0], rtc_en};
        men_sync_d = {men_sync_q[0], match_en};
        ld_sync_d  = {ld_sync_q[0], load_req_tgl};
        clr_sync_d = {clr_sync_q[0], sts_clr_tgl};
        ld_del_d   = ld_s;
        clr_del_d  = clr_s;
    end

    // Counter update with load > increment > hold priority; pulses are recomputed every cycle so they last one cycle
    always_comb begin
        load_evt = ld_s ^ ld_del_q;
        clr_evt  = clr_s ^ clr_del_q;
        inc      = en_s & tick_en & ~load_evt;
        cnt_inc  = cnt_q + CNT_W'(1);
        cnt_d    = load_evt ? load_val : (inc ? cnt_inc : cnt_q);
        ack_d    = load_evt ? ld_s : ack_q;
        wp_d     = inc & (&cnt_q);
        mp_d     = inc & men_s & (cnt_inc == match_val);
        sts_d    = mp_d | (sts_q & ~clr_evt);
    end

    // State register with asynchronous active-low reset; a pending load is simply dropped
    always_ff @(posedge i_rtc_ext_clk or negedge presetn) begin
        if (!presetn) begin
            en_sync_q  <= '0;
            men_sync_q <= '0;
            ld_sync_q  <= '0;
            clr_sync_q <= '0;
            ld_del_q   <= 1'b0;
            clr_del_q  <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            mp_q       <= 1'b0;
            sts_q      <= 1'b0;
            wp_q       <= 1'b0;
        end else begin
            en_sync_q  <= en_sync_d;
            men_sync_q <= men_sync_d;
            ld_sync_q  <= ld_sync_d;
            clr_sync_q <= clr_sync_d;
            ld_del_q   <= ld_del_d;
            clr_del_q  <= clr_del_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            mp_q       <= mp_d;
            sts_q      <= sts_d;
            wp_q       <= wp_d;
        end
    end

    assign cnt_val      = cnt_q;
    assign load_ack_tgl = ack_q;
    assign match_pulse  = mp_q;
    assign match_sts    = sts_q;
    assign wrap_pulse   = wp_q;
endmodule

// File: tb/tb_rtc_counter_core.sv
// tb_rtc_counter_core: randomized and directed scoreboard bench for rtc_counter_core
module tb_rtc_counter_core;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         presetn = 1'b0;
    logic         tick_en = 1'b0;
    logic         rtc_en = 1'b0;
    logic         load_req_tgl = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         match_en = 1'b0;
    logic [W-1:0] match_val = '0;
    logic         sts_clr_tgl = 1'b0;
    logic         load_ack_tgl, match_pulse, match_sts, wrap_pulse;
    logic [W-1:0] cnt_val;

    rtc_counter_core #(.CNT_W(W)) dut (
        .i_rtc_ext_clk(clk),
        .presetn(presetn),
        .tick_en(tick_en),
        .rtc_en(rtc_en),
        .load_req_tgl(load_req_tgl),
        .load_val(load_val),
        .load_ack_tgl(load_ack_tgl),
        .match_en(match_en),
        .match_val(match_val),
        .sts_clr_tgl(sts_clr_tgl),
        .cnt_val(cnt_val),
        .match_pulse(match_pulse),
        .match_sts(match_sts),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         ack;
        logic         mp;
        logic         sts;
        logic         wp;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: controls act two edges after they are sampled (history of sampled inputs)
    logic [W-1:0] m_cnt;
    logic         m_ack, m_mp, m_sts, m_wp;
    logic [2:0]   h_en, h_men, h_ld, h_clr;

    function automatic void model_reset();
        m_cnt = '0; m_ack = 0; m_mp = 0; m_sts = 0; m_wp = 0;
        h_en = '0; h_men = '0; h_ld = '0; h_clr = '0;
    endfunction

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic step_edge();
        bit           ld_ev, clr_ev;
        logic [W-1:0] nxt;
        @(posedge clk);
        if (!presetn) model_reset();
        else begin
            ld_ev  = h_ld[1] != h_ld[2];
            clr_ev = h_clr[1] != h_clr[2];
            m_mp = 0;
            m_wp = 0;
            if (ld_ev) begin
                m_cnt = load_val;
                m_ack = h_ld[1];
            end else if (h_en[1] && tick_en) begin
                nxt  = m_cnt + 1;
                m_wp = (m_cnt == {W{1'b1}});
                m_mp = h_men[1] && (nxt == match_val);
                m_cnt = nxt;
            end
            if (m_mp) m_sts = 1;
            else if (clr_ev) m_sts = 0;
            h_en  = {h_en[1:0], rtc_en};
            h_men = {h_men[1:0], match_en};
            h_ld  = {h_ld[1:0], load_req_tgl};
            h_clr = {h_clr[1:0], sts_clr_tgl};
        end
        exp_q.push_back({m_cnt, m_ack, m_mp, m_sts, m_wp});
    endtask

    task automatic cyc();
        step_edge();
        @(negedge clk);
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic tick();
        tick_en = 1;
        cyc();
        tick_en = 0;
        cyc();
    endtask

    task automatic do_load(logic [W-1:0] v);
        load_val = v;
        load_req_tgl = ~load_req_tgl;
        cycles(3);
    endtask

    // Monitor: every edge the DUT presents a new output set, compared against the queued expectation
    initial begin : mon
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {cnt_val, load_ack_tgl, match_pulse, match_sts, wrap_pulse};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got cnt=%h ack=%b mp=%b sts=%b wp=%b expected cnt=%h ack=%b mp=%b sts=%b wp=%b",
                             $time, a.cnt, a.ack, a.mp, a.sts, a.wp, e.cnt, e.ack, e.mp, e.sts, e.wp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #1;
        chk("reset_cnt", cnt_val, 0);
        chk("reset_ack", load_ack_tgl, 0);
        cycles(2);
        presetn = 1;
        rtc_en = 1;
        cycles(3);
        for (int i = 0; i < 5; i++) tick();
        chk("count5", cnt_val, 5);
        chk("count5_sts", match_sts, 0);
        chk("count5_pulses", {match_pulse, wrap_pulse}, 0);

        for (int i = 0; i < 5; i++) tick();
        load_val = 16'h1234;
        load_req_tgl = 1;
        cycles(2);
        chk("load_not_yet", cnt_val, 10);
        tick_en = 1;
        cyc();
        tick_en = 0;
        chk("load_val", cnt_val, 16'h1234);
        chk("load_ack", load_ack_tgl, 1);
        cyc();
        tick();
        chk("load_next_tick", cnt_val, 16'h1235);

        match_en = 1;
        match_val = 7;
        do_load(5);
        tick();
        chk("pre_match", cnt_val, 6);
        tick_en = 1;
        cyc();
        tick_en = 0;
        chk("match_cnt", cnt_val, 7);
        chk("match_pulse", match_pulse, 1);
        chk("match_sts", match_sts, 1);
        cyc();
        chk("match_pulse_end", match_pulse, 0);
        tick();
        chk("sts_sticky", match_sts, 1);
        sts_clr_tgl = 1;
        cycles(2);
        chk("clr_not_yet", match_sts, 1);
        cyc();
        chk("clr_done", match_sts, 0);
        match_val = 10;
        tick();
        sts_clr_tgl = 0;
        cycles(2);
        tick_en = 1;
        cyc();
        tick_en = 0;
        chk("coinc_cnt", cnt_val, 10);
        chk("coinc_sts", match_sts, 1);
        cyc();

        match_val = 0;
        do_load(16'hFFFF);
        tick_en = 1;
        cyc();
        tick_en = 0;
        chk("wrap_cnt", cnt_val, 0);
        chk("wrap_pulse", wrap_pulse, 1);
        chk("wrap_match", match_pulse, 1);
        cyc();
        chk("wrap_pulse_end", wrap_pulse, 0);

        do_load(20);
        rtc_en = 0;
        cycles(2);
        tick_en = 1;
        cycles(10);
        tick_en = 0;
        chk("disabled_hold", cnt_val, 20);
        do_load(16'h55);
        chk("disabled_load", cnt_val, 16'h55);
        chk("disabled_ack", load_ack_tgl, 1);

        load_val = 16'h99;
        load_req_tgl = 0;
        step_edge();
        step_edge();
        #2;
        presetn = 0;
        model_reset();
        #1;
        chk("async_cnt", cnt_val, 0);
        chk("async_ack", load_ack_tgl, 0);
        chk("async_sts", match_sts, 0);
        @(negedge clk);
        cycles(2);
        presetn = 1;
        cycles(5);
        chk("post_reset_ack", load_ack_tgl, 0);
        chk("post_reset_cnt", cnt_val, 0);

        rtc_en = 1;
        for (int i = 0; i < 3000; i++) begin
            tick_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) rtc_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) match_en = ~match_en;
            if ($urandom_range(0, 9) == 0) match_val = m_cnt + W'($urandom_range(0, 6));
            if (m_ack == load_req_tgl && $urandom_range(0, 24) == 0) begin
                load_val = ($urandom_range(0, 3) == 0) ? 16'hFFFF - W'($urandom_range(0, 4)) : W'($urandom);
                load_req_tgl = ~load_req_tgl;
            end
            if ($urandom_range(0, 24) == 0) sts_clr_tgl = ~sts_clr_tgl;
            cyc();
        end
        tick_en = 0;
        cycles(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rtc_counter_core.md
# rtc_counter_core

Free-running RTC time counter clocked by `i_rtc_ext_clk`, advanced by the one-cycle count tick produced by the RTC clock divider stage. It takes APB-side control (enable, load, status clear) across the clock-domain boundary through internal synchronisers and a toggle handshake. It generates a match interrupt pulse, a sticky match status and a wrap pulse for the RTC register and interrupt logic.

## Interface
Parameters:
- `CNT_W`, default 32: counter, load value and match value width (8..32).

Ports:
- `i_rtc_ext_clk`  in  1  RTC clock; all state is on its rising edge.
- `presetn`  in  1  asynchronous active-low reset.
- `tick_en`  in  1  count tick from the divider. One `i_rtc_ext_clk` cycle wide. Already in this domain.
- `rtc_en`  in  1  counter enable, level, pclk domain. Synchronised internally.
- `load_req_tgl`  in  1  load request, pclk domain. Each toggle is one request.
- `load_val`  in  CNT_W  value to load. Held stable by the source from toggle until ack.
- `load_ack_tgl`  out  1  toggles once per completed load.
- `match_en`  in  1  match enable, pclk domain, quasi-static. Synchronised internally.
- `match_val`  in  CNT_W  match compare value, quasi-static.
- `sts_clr_tgl`  in  1  match-status clear request, pclk domain. Each toggle is one request.
- `cnt_val`  out  CNT_W  current counter value, registered.
- `match_pulse`  out  1  one-cycle pulse when the count reaches `match_val`.
- `match_sts`  out  1  sticky match status.
- `wrap_pulse`  out  1  one-cycle pulse when the count wraps from all-ones to zero.

## Operation
- **Synchronisers.** `rtc_en`, `match_en`, `load_req_tgl` and `sts_clr_tgl` each pass through 2-flop synchronisers. Their synchronised versions are `en_s`, `men_s`, `ld_s` and `clr_s`.
- **Edge detection.** A third flop on `ld_s` and on `clr_s` gives edge detection. A load event is `ld_s != ld_d`. A clear event is `clr_s != clr_d`.
- **Priority each cycle:** load > increment > hold.
- **Load.**
  - Sets `cnt_val <= load_val` and `load_ack_tgl <= ld_s`.
  - No increment happens that cycle, even if `tick_en` is high. That tick is lost.
  - Load works whether `en_s` is 0 or 1.
  - Load never produces `match_pulse` or `wrap_pulse`.
- **Increment.**
  - Occurs when `en_s && tick_en && !load`: `cnt_val <= cnt_val + 1`, modulo 2^CNT_W.
  - If `cnt_val` was all-ones, the count becomes 0 and `wrap_pulse` is 1 in the following cycle.
- **Match.**
  - On an increment where `men_s == 1` and `cnt_val + 1 == match_val`, `match_pulse` is 1 in the following cycle. That is the same cycle in which `cnt_val` shows `match_val`.
  - In that same cycle `match_sts` is set.
  - A wrap to 0 with `match_val == 0` gives both `match_pulse` and `wrap_pulse`.
- **Status clear.**
  - A clear event sets `match_sts <= 0`.
  - If a set and a clear happen in the same cycle, the set wins and `match_sts` stays 1.
- **Enable low.** When `en_s == 0`, `cnt_val` freezes and ticks are ignored. No state is lost.
- **Pulse width.** `match_pulse` and `wrap_pulse` are cleared every cycle in which no new event occurs.
- **Control-value changes.** Changing `match_val` never generates a match by itself. Only an increment can.

## Timing
- **Reset values:** `cnt_val = 0`, `load_ack_tgl = 0`, `match_pulse = 0`, `match_sts = 0`, `wrap_pulse = 0`. All synchroniser and edge flops are 0.
- **Reset mid-operation:** `presetn` low takes effect immediately and asynchronously. A pending load is dropped and no ack is returned. After reset the source must also reset its toggle to 0.
- **Load latency.** From a `load_req_tgl` change sampled at edge N:
  - edge N+1 updates `ld_s`;
  - edge N+2 loads `cnt_val` and toggles `load_ack_tgl`.
  
  That is 3 `i_rtc_ext_clk` edges including the sampling edge.
- **Clear latency.** Same as load: `match_sts` clears at edge N+2.
- **Enable latency.** `rtc_en` and `match_en` take effect 2 edges after sampling. A tick inside that window uses the old value.
- **Load handshake.** The source must not toggle again, or change `load_val`, until it sees `load_ack_tgl == load_req_tgl` in the pclk domain. A second toggle before ack is not supported.
- **Increment latency.** `cnt_val` updates at the edge where `tick_en = 1` is sampled. `match_pulse` and `wrap_pulse` are registered at that same edge and last exactly 1 cycle.
- **Back-to-back ticks.** `tick_en` high on consecutive cycles must increment on every cycle. This case covers a divide-by-1 divider configuration.

## Test plan
- **Reset and count.** Release reset, `rtc_en = 1`, `tick_en` pulsed 5 times → `cnt_val = 5`. No pulses, `match_sts = 0`.
- **Load during tick.** `cnt_val = 10`, `load_val = 0x1234`, toggle `load_req_tgl`, with `tick_en` high on the load edge → `cnt_val = 0x1234` exactly 3 edges later, `load_ack_tgl` toggles on that edge, the tick is lost, and the next tick gives `0x1235`.
- **Match, sticky and clear.** `match_en = 1`, `match_val = 7`, count from 5.
  - Two ticks → `match_pulse` is 1 for one cycle with `cnt_val = 7`; `match_sts = 1` and stays set after further ticks.
  - Toggle `sts_clr_tgl` → `match_sts = 0` 3 edges later.
  - A clear coincident with a new match → `match_sts` stays 1.
- **Wrap.** Load all-ones, `match_val = 0`, one tick → `cnt_val = 0`, with `wrap_pulse` and `match_pulse` both high for 1 cycle.
- **Enable gating.** Deassert `rtc_en` at `cnt_val = 20`, apply 10 ticks → value stays 20 from the 3rd edge onward. A load issued while disabled still loads and acks.
- **Async reset mid-load.** Toggle `load_req_tgl`, assert `presetn` low 1 edge later → all outputs return to reset values immediately. After release, `cnt_val = 0` and no ack occurs.
